// File: rtl/soc_pio_pkg.sv
// Shared definitions for the lightweight-bridge PIO slaves: register word
// addresses, parameter limits and the Avalon-MM write-strobe helper.
package soc_pio_pkg;

    localparam int unsigned ADDR_W      = 3;
    localparam int unsigned WIDTH_MAX   = 32;
    localparam int unsigned DEB_W_MAX   = 20;
    localparam int unsigned SYNC_MIN    = 2;
    localparam int unsigned SYNC_MAX    = 4;

    localparam logic [ADDR_W-1:0] ADDR_DATA       = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN    = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_DEB_LIMIT  = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_LEVEL_MODE = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_RAW        = 3'd7;

    // A slave write happens when selected with the active-low strobe low.
    function automatic logic avalon_write(input logic chipselect, input logic write_n);
        return chipselect & ~write_n;
    endfunction

endpackage

// File: rtl/pio_dbx_bit.sv
// One input bit: synchroniser chain, debounce counter, debounced state and
// its one-cycle-delayed copy for edge detection.
//   clk, reset_n  : clock, async active-low reset
//   in_bit        : asynchronous external input
//   deb_limit     : debounce limit L (0 behaves as 1)
//   sync          : synchronised input (registered)
//   deb           : debounced state (registered)
//   rise_c/fall_c : combinational edge strobes of deb
module pio_dbx_bit
    import soc_pio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_bit,
    input  logic [DEB_W-1:0] deb_limit,
    output logic             sync,
    output logic             deb,
    output logic             rise_c,
    output logic             fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEB_W-1:0]       cnt;
    logic [DEB_W-1:0]       cnt_nxt;
    logic                   deb_nxt;
    logic                   deb_q;
    logic [DEB_W:0]         cnt_inc;
    logic [DEB_W:0]         limit_eff;

    // Metastability chain; the last stage is the usable sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // One extra bit keeps the compare free of wrap; a limit of 0 acts as 1.
    assign cnt_inc   = {1'b0, cnt} + (DEB_W+1)'(1);
    assign limit_eff = (deb_limit == '0) ? (DEB_W+1)'(1) : {1'b0, deb_limit};

    // Debounce: count consecutive mismatch cycles, accept the new level on
    // the L-th. Using >= lets a lowered limit take effect on the next mismatch,
    // and since cnt can never pass all-ones without that compare firing, it
    // cannot wrap.
    always_comb begin
        cnt_nxt = '0;
        deb_nxt = deb;
        if (sync != deb) begin
            if (cnt_inc >= limit_eff) begin
                deb_nxt = sync;
            end else begin
                cnt_nxt = cnt_inc[DEB_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            deb   <= deb_nxt;
            deb_q <= deb;
        end
    end

    assign rise_c = deb & ~deb_q;
    assign fall_c = ~deb & deb_q;

endmodule

// File: rtl/soc_system_pio_in_dbx.sv
// Avalon-MM input PIO with per-bit synchronisation, programmable debounce,
// rising/falling edge capture and level- or edge-sourced interrupts.
//   clk, reset_n        : clock, async active-low reset
//   address, chipselect : register word address, slave select
//   write_n, writedata  : active-low write strobe, write data
//   readdata            : registered read data, 1-cycle latency
//   in_port             : asynchronous external inputs
//   irq                 : registered level-high interrupt
module soc_system_pio_in_dbx
    import soc_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 14,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_W       = 16,
    parameter int unsigned DEB_DEFAULT = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    logic [WIDTH-1:0] sync_vec;
    logic [WIDTH-1:0] deb_vec;
    logic [WIDTH-1:0] rise_vec;
    logic [WIDTH-1:0] fall_vec;

    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] level_mode;
    logic [WIDTH-1:0] edge_cap;
    logic [DEB_W-1:0] deb_limit;

    logic             wr;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] edge_cap_nxt;
    logic [WIDTH-1:0] src;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    // Upper write-data bits are don't-care for narrow configurations.
    assign unused_wdata = &{1'b0, writedata};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_dbx_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_W       (DEB_W)
        ) u_bit (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_bit    (in_port[i]),
            .deb_limit (deb_limit),
            .sync      (sync_vec[i]),
            .deb       (deb_vec[i]),
            .rise_c    (rise_vec[i]),
            .fall_c    (fall_vec[i])
        );
    end

    assign wr = avalon_write(chipselect, write_n);
    assign ev = (rise_vec & rise_en) | (fall_vec & fall_en);

    // Write-1-to-clear; a same-cycle event wins over the clear.
    always_comb begin
        cap_clr = '0;
        if (wr && (address == ADDR_EDGE_CAP)) begin
            cap_clr = writedata[WIDTH-1:0];
        end
        edge_cap_nxt = (edge_cap & ~cap_clr) | ev;
    end

    assign src = (level_mode & deb_vec) | (~level_mode & edge_cap);

    // Read mux; unimplemented upper bits read as zero.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:       rd_mux = 32'(deb_vec);
            ADDR_RISE_EN:    rd_mux = 32'(rise_en);
            ADDR_IRQ_MASK:   rd_mux = 32'(irq_mask);
            ADDR_EDGE_CAP:   rd_mux = 32'(edge_cap);
            ADDR_FALL_EN:    rd_mux = 32'(fall_en);
            ADDR_DEB_LIMIT:  rd_mux = 32'(deb_limit);
            ADDR_LEVEL_MODE: rd_mux = 32'(level_mode);
            ADDR_RAW:        rd_mux = 32'(sync_vec);
            default:         rd_mux = '0;
        endcase
    end

    // Register file, capture, interrupt and read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en    <= '0;
            fall_en    <= '0;
            irq_mask   <= '0;
            level_mode <= '0;
            deb_limit  <= DEB_W'(DEB_DEFAULT);
            edge_cap   <= '0;
            irq        <= 1'b0;
            readdata   <= '0;
        end else begin
            if (wr) begin
                case (address)
                    ADDR_RISE_EN:    rise_en    <= writedata[WIDTH-1:0];
                    ADDR_IRQ_MASK:   irq_mask   <= writedata[WIDTH-1:0];
                    ADDR_FALL_EN:    fall_en    <= writedata[WIDTH-1:0];
                    ADDR_DEB_LIMIT:  deb_limit  <= writedata[DEB_W-1:0];
                    ADDR_LEVEL_MODE: level_mode <= writedata[WIDTH-1:0];
                    default:         ;
                endcase
            end
            edge_cap <= edge_cap_nxt;
            irq      <= |(src & irq_mask);
            readdata <= rd_mux;
        end
    end

endmodule
